// File: rtl/regfile_pkg.sv
// Shared definitions for the register file, its write arbiter and the hazard unit.
package regfile_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NREGS  = 32;
    // One extra bit so the clear counter can represent NREGS itself.
    localparam int unsigned CNT_W  = ADDR_W + 1;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    typedef enum logic {
        REQ_A,
        REQ_B
    } req_id_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

endpackage

// File: rtl/wr_holding_slot.sv
// One-entry write buffer (valid/addr/data) sitting in front of the register-file write port.
// Ports:
//   clock, reset  - rising-edge clock, asynchronous active-high reset
//   load          - capture load_entry (takes priority over drain, so a slot can refill as it drains)
//   drain         - entry has been granted and leaves the slot
//   load_entry    - incoming addr/data
//   full          - slot holds a pending write
//   entry         - held addr/data
module wr_holding_slot
    import regfile_pkg::*;
(
    input  logic      clock,
    input  logic      reset,
    input  logic      load,
    input  logic      drain,
    input  wr_entry_t load_entry,
    output logic      full,
    output wr_entry_t entry
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            full  <= 1'b0;
            entry <= '0;
        end else if (load) begin
            full  <= 1'b1;
            entry <= load_entry;
        end else if (drain) begin
            full  <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owner of the register file's single write port. Clears all registers after reset,
// then merges writes from the writeback pipeline (A) and the multi-cycle/load path (B)
// round-robin, one write per cycle, and reports pending writes for hazard detection.
// Ports:
//   clock, reset                  - rising-edge clock, asynchronous active-high reset
//   a_valid/a_ready/a_addr/a_data - requester A handshake and write payload
//   b_valid/b_ready/b_addr/b_data - requester B handshake and write payload
//   enc/addrc/datac               - registered register-file write port
//   init_done                     - clear sequence finished
//   q_addr/q_hit                  - hazard query: is a write to q_addr still pending
module regfile_write_arbiter
    import regfile_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              enc,
    output logic [ADDR_W-1:0] addrc,
    output logic [DATA_W-1:0] datac,
    output logic              init_done,
    input  logic [ADDR_W-1:0] q_addr,
    output logic              q_hit
);

    state_t            state, state_next;
    logic [CNT_W-1:0]  clr_cnt, clr_cnt_next;
    req_id_t           rr_ptr, rr_next;
    logic              enc_next;
    logic [ADDR_W-1:0] addrc_next;
    logic [DATA_W-1:0] datac_next;
    logic              init_done_next;

    wr_entry_t a_in, b_in, a_entry, b_entry;
    logic      a_full, b_full;
    logic      grant_a, grant_b;
    logic      a_load, b_load;
    logic      run;

    assign run = (state == ST_RUN);

    // At most one grant; the pointer only matters when both slots are full.
    assign grant_a = run & a_full & (~b_full | (rr_ptr == REQ_A));
    assign grant_b = run & b_full & (~a_full | (rr_ptr == REQ_B));

    // A slot being drained this cycle may be refilled on the same edge.
    assign a_ready = run & (~a_full | grant_a);
    assign b_ready = run & (~b_full | grant_b);
    assign a_load  = a_valid & a_ready;
    assign b_load  = b_valid & b_ready;

    assign a_in = '{addr: a_addr, data: a_data};
    assign b_in = '{addr: b_addr, data: b_data};

    wr_holding_slot u_slot_a (
        .clock      (clock),
        .reset      (reset),
        .load       (a_load),
        .drain      (grant_a),
        .load_entry (a_in),
        .full       (a_full),
        .entry      (a_entry)
    );

    wr_holding_slot u_slot_b (
        .clock      (clock),
        .reset      (reset),
        .load       (b_load),
        .drain      (grant_b),
        .load_entry (b_in),
        .full       (b_full),
        .entry      (b_entry)
    );

    // Pending write: still buffered, or being written this cycle. Register 0 never hazards.
    assign q_hit = run & (q_addr != '0) &
                   ((a_full & (a_entry.addr == q_addr)) |
                    (b_full & (b_entry.addr == q_addr)) |
                    (enc & (addrc == q_addr)));

    // Next-state and write-port values.
    always_comb begin
        state_next     = state;
        clr_cnt_next   = clr_cnt;
        rr_next        = rr_ptr;
        enc_next       = 1'b0;
        addrc_next     = addrc;
        datac_next     = datac;
        init_done_next = init_done;
        case (state)
            ST_CLEAR: begin
                enc_next     = 1'b1;
                addrc_next   = clr_cnt[ADDR_W-1:0];
                datac_next   = '0;
                clr_cnt_next = clr_cnt + CNT_W'(1);
                if (clr_cnt == CNT_W'(NREGS - 1)) begin
                    state_next     = ST_RUN;
                    init_done_next = 1'b1;
                end
            end
            ST_RUN: begin
                // Register 0 is hardwired: the grant is consumed but no write is issued.
                if (grant_a) begin
                    enc_next   = (a_entry.addr != '0);
                    addrc_next = a_entry.addr;
                    datac_next = a_entry.data;
                    rr_next    = REQ_B;
                end else if (grant_b) begin
                    enc_next   = (b_entry.addr != '0);
                    addrc_next = b_entry.addr;
                    datac_next = b_entry.data;
                    rr_next    = REQ_A;
                end
            end
            default: state_next = ST_CLEAR;
        endcase
    end

    // State, pointer and write-port registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_CLEAR;
            clr_cnt   <= '0;
            rr_ptr    <= REQ_A;
            enc       <= 1'b0;
            addrc     <= '0;
            datac     <= '0;
            init_done <= 1'b0;
        end else begin
            state     <= state_next;
            clr_cnt   <= clr_cnt_next;
            rr_ptr    <= rr_next;
            enc       <= enc_next;
            addrc     <= addrc_next;
            datac     <= datac_next;
            init_done <= init_done_next;
        end
    end

endmodule
